// File: rtl/rs_syndrome_calc.sv
// RS(N, N-2T) syndrome calculator over GF(2^8): one Horner accumulator per syndrome,
// with the completed syndrome bank registered for the downstream key-equation solver.
module rs_syndrome_calc #(
    parameter int       N         = 255,
    parameter int       T         = 8,
    parameter int       FCR       = 0,
    parameter logic [8:0] PRIM_POLY = 9'h11D
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        din,
    input  logic              din_valid,
    input  logic              sop,
    output logic [16*T-1:0]   synd,
    output logic              synd_valid,
    output logic              no_err,
    output logic              busy,
    output logic              abort
);

    localparam int unsigned NS   = 2 * T;
    localparam logic [7:0]  LAST = 8'(N - 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? PRIM_POLY[7:0] : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] alpha_pow(input int unsigned k);
        logic [7:0] r;
        r = 8'h01;
        for (int unsigned i = 0; i < (k % 255); i++) r = xtime(r);
        return r;
    endfunction

    state_t          state;
    logic [7:0]      cnt;
    logic [7:0]      acc      [NS];
    logic [7:0]      step     [NS];
    logic [16*T-1:0] step_bank;
    logic            step_zero;

    // Each multiplier has a constant operand, so it reduces to a fixed XOR network.
    for (genvar g = 0; g < NS; g++) begin : g_step
        localparam logic [7:0] ROOT = alpha_pow(FCR + g);
        assign step[g] = gf_mul(acc[g], ROOT) ^ din;
    end

    always_comb begin
        step_bank = '0;
        step_zero = 1'b1;
        for (int unsigned j = 0; j < NS; j++) begin
            step_bank[8*j +: 8] = step[j];
            if (step[j] != '0) step_zero = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            synd       <= '0;
            synd_valid <= 1'b0;
            no_err     <= 1'b0;
            busy       <= 1'b0;
            abort      <= 1'b0;
            for (int unsigned j = 0; j < NS; j++) acc[j] <= '0;
        end else begin
            synd_valid <= 1'b0;
            abort      <= 1'b0;
            if (din_valid && sop) begin
                abort <= (state == ACCUM);
                for (int unsigned j = 0; j < NS; j++) acc[j] <= din;
                if (N == 1) begin
                    for (int unsigned j = 0; j < NS; j++) synd[8*j +: 8] <= din;
                    no_err     <= (din == '0);
                    synd_valid <= 1'b1;
                    cnt        <= '0;
                    state      <= IDLE;
                    busy       <= 1'b0;
                end else begin
                    cnt   <= 8'd1;
                    state <= ACCUM;
                    busy  <= 1'b1;
                end
            end else if (din_valid && state == ACCUM) begin
                // The final Horner step lands in synd directly; acc is free for the next sop.
                if (cnt == LAST) begin
                    synd       <= step_bank;
                    no_err     <= step_zero;
                    synd_valid <= 1'b1;
                    state      <= IDLE;
                    busy       <= 1'b0;
                end else begin
                    for (int unsigned j = 0; j < NS; j++) acc[j] <= step[j];
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Directed bench for rs_syndrome_calc: vector table of sparse codewords plus
// stall, abort, back-to-back and mid-frame reset sequences.
module tb_rs_syndrome_calc;

    localparam int N  = 255;
    localparam int T  = 8;
    localparam int NS = 2 * T;

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      din;
    logic            din_valid;
    logic            sop;
    logic [8*NS-1:0] synd;
    logic            synd_valid;
    logic            no_err;
    logic            busy;
    logic            abort;

    rs_syndrome_calc #(.N(N), .T(T), .FCR(0), .PRIM_POLY(9'h11D)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .sop        (sop),
        .synd       (synd),
        .synd_valid (synd_valid),
        .no_err     (no_err),
        .busy       (busy),
        .abort      (abort)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int abort_count = 0;

    always @(negedge clk) if (abort === 1'b1) abort_count++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] gexp [255];
    int         glog [256];
    logic [7:0] frame [N];
    logic [7:0] model [NS];

    typedef struct {
        int         deg_a;
        logic [7:0] val_a;
        int         deg_b;
        logic [7:0] val_b;
        logic [7:0] s0;
        logic [7:0] s1;
        logic [7:0] s2;
        logic       ne;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Log/antilog evaluation of r(alpha^j), independent of Horner ordering.
    task automatic calc_model();
        for (int j = 0; j < NS; j++) begin
            logic [7:0] s;
            s = 8'h00;
            for (int i = 0; i < N; i++) begin
                if (frame[i] != 8'h00)
                    s = s ^ gexp[(glog[frame[i]] + (N - 1 - i) * j) % 255];
            end
            model[j] = s;
        end
    endtask

    task automatic clear_frame();
        for (int i = 0; i < N; i++) frame[i] = 8'h00;
    endtask

    task automatic check_synd(input string tag);
        calc_model();
        for (int j = 0; j < NS; j++)
            check($sformatf("%s_S%0d", tag, j), {24'h0, synd[8*j +: 8]}, {24'h0, model[j]});
    endtask

    task automatic send(input logic [7:0] d, input logic s);
        din = d; sop = s; din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0; sop = 1'b0;
    endtask

    task automatic idle_cycle();
        din_valid = 1'b0; sop = 1'b0;
        @(posedge clk); #1;
    endtask

    // Streams frame[]; ends #1 after the last symbol's edge, leaving synd_valid observable.
    task automatic run_frame(input int stall_at, input int stall_n, input logic hold_en,
                             input logic [8*NS-1:0] hold_val, output int first_valid,
                             output logic abort_first, output logic hold_ok);
        int edges;
        edges = 0; first_valid = 0; hold_ok = 1'b1; abort_first = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i == stall_at) begin
                for (int k = 0; k < stall_n; k++) begin
                    idle_cycle();
                    edges++;
                    if (synd_valid === 1'b1 && first_valid == 0) first_valid = edges;
                    if (hold_en && synd !== hold_val) hold_ok = 1'b0;
                end
            end
            send(frame[i], i == 0);
            edges++;
            if (i == 0) abort_first = abort;
            if (synd_valid === 1'b1 && first_valid == 0) first_valid = edges;
            if (hold_en && i < N - 1 && synd !== hold_val) hold_ok = 1'b0;
        end
    endtask

    initial begin
        int         fv;
        logic       ab;
        logic       hok;
        int         stall_at;
        int         vcount;
        logic [8*NS-1:0] saved;

        gexp[0] = 8'h01;
        glog[0] = 0;
        glog[1] = 0;
        for (int i = 1; i < 255; i++) begin
            gexp[i] = {gexp[i-1][6:0], 1'b0} ^ (gexp[i-1][7] ? 8'h1D : 8'h00);
            glog[gexp[i]] = i;
        end

        vecs[0] = '{deg_a: 0,   val_a: 8'h00, deg_b: 0, val_b: 8'h00, s0: 8'h00, s1: 8'h00, s2: 8'h00, ne: 1'b1};
        vecs[1] = '{deg_a: 0,   val_a: 8'h01, deg_b: 0, val_b: 8'h00, s0: 8'h01, s1: 8'h01, s2: 8'h01, ne: 1'b0};
        vecs[2] = '{deg_a: 254, val_a: 8'h01, deg_b: 0, val_b: 8'h00, s0: 8'h01, s1: 8'h8E, s2: 8'h47, ne: 1'b0};
        vecs[3] = '{deg_a: 1,   val_a: 8'h01, deg_b: 0, val_b: 8'h00, s0: 8'h01, s1: 8'h02, s2: 8'h04, ne: 1'b0};
        vecs[4] = '{deg_a: 0,   val_a: 8'h5A, deg_b: 1, val_b: 8'h03, s0: 8'h59, s1: 8'h5C, s2: 8'h56, ne: 1'b0};
        vecs[5] = '{deg_a: 8,   val_a: 8'h01, deg_b: 0, val_b: 8'h00, s0: 8'h01, s1: 8'h1D, s2: 8'h4C, ne: 1'b0};

        reset = 1'b1; din = 8'h00; din_valid = 1'b0; sop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_synd_zero", {31'h0, synd == '0}, 32'h1);
        check("reset_synd_valid", {31'h0, synd_valid}, 32'h0);
        check("reset_no_err", {31'h0, no_err}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        reset = 1'b0;
        idle_cycle();

        // Ignored: din_valid without sop in IDLE, sop without din_valid.
        din = 8'h77; din_valid = 1'b1; sop = 1'b0; @(posedge clk); #1;
        din_valid = 1'b0; sop = 1'b1; @(posedge clk); #1;
        sop = 1'b0;
        check("idle_ignore_busy", {31'h0, busy}, 32'h0);

        for (int v = 0; v < 6; v++) begin
            clear_frame();
            frame[N-1-vecs[v].deg_a] = frame[N-1-vecs[v].deg_a] ^ vecs[v].val_a;
            frame[N-1-vecs[v].deg_b] = frame[N-1-vecs[v].deg_b] ^ vecs[v].val_b;
            run_frame(-1, 0, 1'b0, '0, fv, ab, hok);
            check($sformatf("v%0d_latency", v), fv, N);
            check($sformatf("v%0d_s0", v), {24'h0, synd[7:0]}, {24'h0, vecs[v].s0});
            check($sformatf("v%0d_s1", v), {24'h0, synd[15:8]}, {24'h0, vecs[v].s1});
            check($sformatf("v%0d_s2", v), {24'h0, synd[23:16]}, {24'h0, vecs[v].s2});
            check($sformatf("v%0d_no_err", v), {31'h0, no_err}, {31'h0, vecs[v].ne});
            check_synd($sformatf("v%0d", v));
            idle_cycle();
            check($sformatf("v%0d_valid_pulse", v), {31'h0, synd_valid}, 32'h0);
            check($sformatf("v%0d_busy_done", v), {31'h0, busy}, 32'h0);
        end

        // Stall of 3 cycles at a random point inside the degree-0 frame.
        clear_frame();
        frame[N-1] = 8'h01;
        stall_at = $urandom_range(1, N - 1);
        run_frame(stall_at, 3, 1'b0, '0, fv, ab, hok);
        check("stall_latency", fv, N + 3);
        check("stall_no_err", {31'h0, no_err}, 32'h0);
        for (int j = 0; j < NS; j++)
            check($sformatf("stall_S%0d", j), {24'h0, synd[8*j +: 8]}, 32'h01);
        idle_cycle();

        // Frame A abandoned after 100 symbols by frame B's sop.
        saved = synd;
        vcount = 0;
        for (int i = 0; i < 100; i++) begin
            send(8'hA5, i == 0);
            if (synd_valid === 1'b1) vcount++;
        end
        check("frameA_no_valid", vcount, 0);
        check("frameA_busy", {31'h0, busy}, 32'h1);
        clear_frame();
        frame[N-1] = 8'h01;
        frame[N-4] = 8'h07;
        run_frame(-1, 0, 1'b1, saved, fv, ab, hok);
        check("abort_pulse", {31'h0, ab}, 32'h1);
        check("abort_synd_untouched", {31'h0, hok}, 32'h1);
        check("frameB_latency", fv, N);
        check("abort_count_B", abort_count, 1);
        check_synd("frameB");
        saved = synd;

        // Frame C starts in B's synd_valid cycle; B's bank must hold until C completes.
        clear_frame();
        frame[0] = 8'h01;
        frame[N-1] = 8'hFF;
        run_frame(-1, 0, 1'b1, saved, fv, ab, hok);
        check("frameC_hold_B", {31'h0, hok}, 32'h1);
        check("frameC_no_abort", {31'h0, ab}, 32'h0);
        check("frameC_latency", fv, N);
        check("abort_count_C", abort_count, 1);
        check_synd("frameC");
        idle_cycle();

        // Reset 50 symbols into a frame.
        for (int i = 0; i < 50; i++) send(8'h33, i == 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid_synd", {31'h0, synd == '0}, 32'h1);
        check("rst_mid_valid", {31'h0, synd_valid}, 32'h0);
        check("rst_mid_no_err", {31'h0, no_err}, 32'h0);
        check("rst_mid_busy", {31'h0, busy}, 32'h0);
        check("rst_mid_abort", {31'h0, abort}, 32'h0);
        vcount = 0;
        for (int k = 0; k < 5; k++) begin
            idle_cycle();
            if (synd_valid === 1'b1 || abort === 1'b1) vcount++;
        end
        check("rst_no_spurious", vcount, 0);
        clear_frame();
        run_frame(-1, 0, 1'b0, '0, fv, ab, hok);
        check("rst_frame_latency", fv, N);
        check("rst_frame_no_err", {31'h0, no_err}, 32'h1);
        check("rst_frame_synd_zero", {31'h0, synd == '0}, 32'h1);
        check("abort_count_end", abort_count, 1);
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs_syndrome_calc.md
Name: rs_syndrome_calc

Overview:
- Computes the 2T syndromes S_j = r(alpha^(FCR+j)), j = 0..2T-1, of a received RS(N, N-2T) codeword over GF(2^8).
- Uses one Horner accumulator per syndrome.
- Sits directly upstream of the Euclidean key-equation solver.
- Its registered syndrome bank drives the Din inputs of the solver's feedback_ckt hold/load registers, which load on synd_valid.

Parameters:
- N, 255, codeword length in symbols (2T+1..255).
- T, 8, error-correcting capability; 2T syndromes produced.
- FCR, 0, exponent of the first consecutive root.
- PRIM_POLY, 9'h11D, field primitive polynomial (alpha = 8'h02).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  8  received symbol, highest-degree coefficient first.
- din_valid  input  1  din is valid this cycle.
- sop  input  1  qualifies din as first symbol of a codeword; meaningful only with din_valid.
- synd  output  16*T  syndrome bank; S_j occupies bits [8j+7:8j].
- synd_valid  output  1  one-cycle pulse: synd updated with a completed codeword.
- no_err  output  1  all syndromes of the last completed codeword are zero; valid from synd_valid until next synd_valid.
- busy  output  1  a codeword is being accumulated.
- abort  output  1  one-cycle pulse: frame abandoned by a new sop.

Behaviour:
- Reset is synchronous, active-high, sampled at the rising clk edge. It clears:
  - accumulators, symbol counter, synd, synd_valid, no_err, busy, abort all to 0;
  - state goes to IDLE.
- Reset mid-frame discards the partial codeword; no synd_valid or abort is generated for it.
- States: IDLE, ACCUM.
- IDLE:
  - din_valid & sop: acc_j <= din for all j; cnt <= 1; go to ACCUM (busy=1).
  - din_valid without sop is ignored.
- ACCUM:
  - din_valid & !sop: acc_j <= acc_j*alpha^(FCR+j) XOR din; cnt <= cnt+1.
  - din_valid low: stall; acc and cnt hold; no timeout.
  - din_valid & sop before the frame completes: restart as in IDLE; abort pulses the next cycle; synd and no_err untouched.
- GF arithmetic:
  - Multiplication by alpha^k uses a per-syndrome constant multiplier reduced modulo PRIM_POLY.
  - Addition is XOR.
  - No carries; all values stay 8 bits.
- Completion (N-th accepted symbol, sampled at edge k):
  - At edge k, synd_j <= acc_j*alpha^(FCR+j) XOR din, i.e. the final Horner step. When N=1 the first symbol also completes the frame and synd_j <= din.
  - At edge k, no_err <= (all new synd_j == 0), synd_valid <= 1 for exactly one cycle, and the state returns to IDLE (busy=0).
  - Latency: synd_valid is high in the cycle directly after the last symbol's sampling edge.
- synd and no_err hold stable until the next completion. The downstream solver may sample them any time after synd_valid.
- Back-to-back frames: a sop accepted in the same cycle synd_valid is high starts a new frame with no bubble.
  - Accumulators are separate from synd, so the outputs are not disturbed.
  - Throughput: one symbol per clock.
- cnt is 8 bits and never wraps: completion at N returns to IDLE before overflow.
- sop asserted without din_valid has no effect.

Test Plan:
- All-zero codeword, N=255, T=8, FCR=0, continuous din_valid:
  - synd_valid exactly 1 cycle after symbol 255;
  - all synd = 8'h00;
  - no_err=1.
- Codeword with only the last symbol (degree 0) = 8'h01:
  - all sixteen S_j = 8'h01; no_err=0.
- Codeword with only the first symbol (degree 254) = 8'h01:
  - S_0 = 8'h01, S_1 = 8'h8E (alpha^-1), S_2 = 8'h47.
- Stall: repeat the single-degree-0 case with din_valid low for 3 random cycles inside the frame:
  - identical syndromes;
  - synd_valid delayed by exactly the stall count.
- Abort and back-to-back:
  - Frame A, sop again after 100 symbols, then full frame B: abort pulses once; only B's syndromes appear.
  - Frame C's sop in B's synd_valid cycle: B's synd held stable until C completes.
- Reset mid-frame after 50 symbols, then a clean all-zero frame:
  - all outputs 0 the cycle after reset;
  - no spurious synd_valid;
  - the following frame completes correctly with no_err=1.
